// File: rtl/icb_pkg.sv
// Shared ICB slave definitions: default bus geometry, response entry layout
// and the byte-address to word-index helper.
package icb_pkg;

    localparam int ICB_BUS_WIDTH = 32;
    localparam int ICB_BYTES     = ICB_BUS_WIDTH / 8;

    // Response FIFO entries are packed in this order: rdata above, err in bit 0.
    typedef struct packed {
        logic [ICB_BUS_WIDTH-1:0] rdata;
        logic                     err;
    } icb_rsp_entry_t;

    function automatic logic [63:0] icb_word_idx(input logic [63:0] addr,
                                                 input int unsigned byte_lg);
        return addr >> byte_lg;
    endfunction

endpackage

// File: rtl/icb_rsp_fifo.sv
// Synchronous FIFO for ICB response entries; extra pointer bit distinguishes
// full from empty.
module icb_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             full_s, do_push_s, do_pop_s;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

    // Pointer advance; a push into a full FIFO is allowed only alongside a pop.
    always_comb begin
        do_pop_s  = pop_i && !empty_o;
        do_push_s = push_i && (!full_s || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {(PW+1){1'b0}};
            rd_ptr_q <= {(PW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/icb_sram_slave.sv
// ICB slave endpoint: decodes commands into single-port SRAM accesses and
// returns in-order responses through a credit-bounded response FIFO.
module icb_sram_slave
    import icb_pkg::*;
#(
    parameter int BUS_WIDTH  = ICB_BUS_WIDTH,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         icb_cmd_valid,
    output logic                         icb_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]        icb_cmd_addr,
    input  logic                         icb_cmd_read,
    input  logic [BUS_WIDTH-1:0]         icb_cmd_wdata,
    input  logic [BUS_WIDTH/8-1:0]       icb_cmd_wmask,
    output logic                         icb_rsp_valid,
    input  logic                         icb_rsp_ready,
    output logic [BUS_WIDTH-1:0]         icb_rsp_rdata,
    output logic                         icb_rsp_err,
    output logic                         sram_en,
    output logic                         sram_we,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
    output logic [BUS_WIDTH-1:0]         sram_wdata,
    output logic [BUS_WIDTH/8-1:0]       sram_wmask,
    input  logic [BUS_WIDTH-1:0]         sram_rdata
);
    localparam int BYTE_LG = $clog2(BUS_WIDTH / 8);
    localparam int MEM_AW  = $clog2(MEM_WORDS);
    localparam int CNT_W   = $clog2(RSP_DEPTH) + 1;
    localparam int ENTRY_W = BUS_WIDTH + 1;

    logic [63:0]        word_idx_s;
    logic               in_range_s, cmd_hs_s, rsp_hs_s;
    logic               p_valid_q, p_valid_d, p_read_q, p_read_d, p_err_q, p_err_d;
    logic [CNT_W-1:0]   fifo_count_s, outstanding_s;
    logic               fifo_empty_s;
    logic [ENTRY_W-1:0] push_data_s, head_s;

    // Credits are counted from registered state only, so rsp_ready never reaches cmd_ready.
    assign outstanding_s = CNT_W'(p_valid_q) + fifo_count_s;
    assign icb_cmd_ready = !rst && (outstanding_s < CNT_W'(RSP_DEPTH));
    assign cmd_hs_s      = icb_cmd_valid && icb_cmd_ready;
    assign icb_rsp_valid = !fifo_empty_s && !rst;
    assign rsp_hs_s      = icb_rsp_valid && icb_rsp_ready;
    assign icb_rsp_rdata = icb_rsp_valid ? head_s[ENTRY_W-1:1] : {BUS_WIDTH{1'b0}};
    assign icb_rsp_err   = icb_rsp_valid ? head_s[0] : 1'b0;
    assign sram_wdata    = icb_cmd_wdata;
    assign sram_wmask    = icb_cmd_wmask;
    assign sram_addr     = word_idx_s[MEM_AW-1:0];

    // Address decode, SRAM strobe and pipeline-register next state.
    always_comb begin
        word_idx_s = icb_word_idx(64'(icb_cmd_addr), BYTE_LG);
        in_range_s = (word_idx_s < 64'(MEM_WORDS));
        sram_en    = cmd_hs_s && in_range_s;
        sram_we    = cmd_hs_s && in_range_s && !icb_cmd_read;
        p_valid_d  = cmd_hs_s;
        p_read_d   = icb_cmd_read;
        p_err_d    = !in_range_s;
        if (p_read_q && !p_err_q) begin
            push_data_s = {sram_rdata, 1'b0};
        end else begin
            push_data_s = {{BUS_WIDTH{1'b0}}, p_err_q};
        end
    end

    // Pipeline register spanning the SRAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_q <= 1'b0;
            p_read_q  <= 1'b0;
            p_err_q   <= 1'b0;
        end else begin
            p_valid_q <= p_valid_d;
            p_read_q  <= p_read_d;
            p_err_q   <= p_err_d;
        end
    end

    icb_rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (p_valid_q),
        .push_data_i (push_data_s),
        .pop_i       (rsp_hs_s),
        .head_o      (head_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s)
    );

endmodule

// File: tb/tb_icb_sram_slave.sv
// Randomised and directed bench for icb_sram_slave against an in-order
// response scoreboard and a word-array memory reference.
module tb_icb_sram_slave;
    localparam int BW = 32;
    localparam int AW = 32;
    localparam int MW = 1024;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [AW-1:0] icb_cmd_addr;
    logic [BW-1:0] icb_cmd_wdata;
    logic [3:0]    icb_cmd_wmask;
    logic          icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [BW-1:0] icb_rsp_rdata;
    logic          sram_en, sram_we;
    logic [9:0]    sram_addr;
    logic [BW-1:0] sram_wdata, sram_rdata;
    logic [3:0]    sram_wmask;

    always #5 clk = ~clk;

    icb_sram_slave #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MEM_WORDS(MW), .RSP_DEPTH(RD)) dut (
        .clk(clk), .rst(rst),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
    );

    // SRAM model and reference memory
    logic [BW-1:0] mem     [MW];
    logic [BW-1:0] ref_mem [MW];

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ready pattern: 0 = hold low, 1 = hold high, 2 = random per cycle
    int   rdy_mode = 1;
    logic rnd_bit  = 1'b0;
    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end
    assign icb_rsp_ready = (rdy_mode == 1) || (rdy_mode == 2 && rnd_bit);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [BW-1:0] rdata;
        logic          err;
        int            cmd_edge;
    } exp_t;
    exp_t exp_q[$];

    bit            lat_chk = 1'b0;
    int            n_rsp = 0;
    logic [BW-1:0] last_rdata;
    logic          last_err;
    bit            hold_f = 1'b0;
    logic [BW-1:0] hold_rdata;
    logic          hold_err;

    // Monitor: everything sampled mid-cycle describes the upcoming rising edge.
    always @(negedge clk) begin : mon
        logic        cmd_hs;
        logic [63:0] idx;
        logic        inr;
        exp_t        e;
        if (rst) begin
            exp_q.delete();
            hold_f = 1'b0;
            check_eq("rst_cmd_ready", icb_cmd_ready, 0);
            check_eq("rst_rsp_valid", icb_rsp_valid, 0);
            check_eq("rst_rsp_rdata", icb_rsp_rdata, 0);
            check_eq("rst_rsp_err", icb_rsp_err, 0);
            check_eq("rst_sram_en", sram_en, 0);
            check_eq("rst_sram_we", sram_we, 0);
        end else begin
            cmd_hs = icb_cmd_valid && icb_cmd_ready;
            idx    = 64'(icb_cmd_addr) >> 2;
            inr    = (idx < 64'(MW));
            check_eq("sram_en", sram_en, cmd_hs && inr);
            if (cmd_hs && inr) begin
                check_eq("sram_we", sram_we, !icb_cmd_read);
                check_eq("sram_addr", sram_addr, idx);
            end
            if (hold_f) begin
                check_eq("rsp_valid_held", icb_rsp_valid, 1);
                check_eq("rsp_rdata_held", icb_rsp_rdata, hold_rdata);
                check_eq("rsp_err_held", icb_rsp_err, hold_err);
            end
            if (icb_rsp_valid && icb_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("rsp_extra", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rsp_rdata", icb_rsp_rdata, e.rdata);
                    check_eq("rsp_err", icb_rsp_err, e.err);
                    if (lat_chk) check_eq("rsp_latency", 64'(cyc + 1 - e.cmd_edge), 64'd2);
                    n_rsp++;
                    last_rdata = icb_rsp_rdata;
                    last_err   = icb_rsp_err;
                end
            end
            hold_f     = icb_rsp_valid && !icb_rsp_ready;
            hold_rdata = icb_rsp_rdata;
            hold_err   = icb_rsp_err;
            if (cmd_hs) begin
                e.cmd_edge = cyc + 1;
                e.err      = !inr;
                e.rdata    = '0;
                if (inr && icb_cmd_read) begin
                    e.rdata = ref_mem[idx[9:0]];
                end else if (inr) begin
                    for (int b = 0; b < 4; b++)
                        if (icb_cmd_wmask[b]) ref_mem[idx[9:0]][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
                end
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] wm, input int budget, output int waited, output bit ok);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = addr;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        ok     = 1'b0;
        waited = 0;
        while (!ok && waited < budget) begin
            @(negedge clk);
            if (icb_cmd_ready) ok = 1'b1;
            else waited++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_ok(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] wm);
        int w;
        bit ok;
        send(rd, addr, wd, wm, 200, w, ok);
        check_eq("cmd_accept_timeout", ok, 1);
    endtask

    task automatic drain();
        int n = 0;
        icb_cmd_valid = 1'b0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check_eq("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic cmp_mem();
        int nmis = 0;
        for (int i = 0; i < MW; i++)
            if (mem[i] !== ref_mem[i]) nmis++;
        check_eq("sram_contents", 64'(nmis), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < MW; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  w, acc, snap;
        bit  ok;
        rst           = 1'b1;
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = 32'h0;
        icb_cmd_wdata = 32'h0;
        icb_cmd_wmask = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_reset", icb_cmd_ready, 1);
        check_eq("rsp_valid_after_reset", icb_rsp_valid, 0);
        @(posedge clk);
        #1;

        // write then read back, checking latency
        lat_chk = 1'b1;
        send_ok(1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
        send_ok(1'b1, 32'h10, 32'h0, 4'h0);
        drain();
        lat_chk = 1'b0;
        check_eq("t1_rdata", last_rdata, 32'hDEADBEEF);
        check_eq("t1_err", last_err, 0);

        // partial byte mask
        send_ok(1'b0, 32'h20, 32'hFFFFFFFF, 4'hF);
        send_ok(1'b0, 32'h20, 32'h11223344, 4'b0101);
        send_ok(1'b1, 32'h20, 32'h0, 4'h0);
        drain();
        check_eq("t2_rdata", last_rdata, 32'hFF22FF44);

        // back-pressure: only RSP_DEPTH accepted while rsp_ready is low
        snap = n_rsp;
        rdy_mode = 0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 32'(i * 4), 32'h0, 4'h0, 3, w, ok);
            if (ok) acc++;
        end
        send(1'b1, 32'h10, 32'h0, 4'h0, 6, w, ok);
        icb_cmd_valid = 1'b0;
        check_eq("bp_fifth_blocked", ok, 0);
        check_eq("bp_accepted", 64'(acc), 64'd4);
        @(negedge clk);
        check_eq("bp_cmd_ready_low", icb_cmd_ready, 0);
        @(posedge clk);
        #1 rdy_mode = 1;
        send_ok(1'b1, 32'h10, 32'h0, 4'h0);
        send_ok(1'b1, 32'h14, 32'h0, 4'h0);
        drain();
        check_eq("bp_rsp_count", 64'(n_rsp - snap), 64'd6);

        // out-of-range read and write
        send_ok(1'b1, 32'h1000, 32'h0, 4'h0);
        drain();
        check_eq("oor_rd_err", last_err, 1);
        check_eq("oor_rd_rdata", last_rdata, 0);
        send_ok(1'b0, 32'h1000, 32'h55, 4'hF);
        drain();
        check_eq("oor_wr_err", last_err, 1);
        cmp_mem();

        // streaming reads at full rate
        lat_chk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 32'(i * 4), 32'h0, 4'h0, 1, w, ok);
            check_eq("stream_ready", 64'(w), 64'd0);
        end
        drain();
        lat_chk = 1'b0;

        // reset with responses queued
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) send_ok(1'b1, 32'(i * 4), 32'h0, 4'h0);
        icb_cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("queued_before_reset", icb_rsp_valid, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_rsp_valid", icb_rsp_valid, 0);
        check_eq("rst_mid_cmd_ready", icb_cmd_ready, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 32'(i * 8), 32'h0, 4'h0, 1, w, ok);
            check_eq("rst_credit_full", ok, 1);
        end
        icb_cmd_valid = 1'b0;
        rdy_mode = 1;
        drain();

        // random traffic with random response back-pressure
        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            icb_cmd_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            if ($urandom_range(0, 15) == 0) a = 32'h1000 + 32'($urandom_range(0, 4095));
            else a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            send_ok(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end
        rdy_mode = 1;
        drain();
        cmp_mem();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
